// File: rtl/transform_streamer.sv
// Streams the lhs/rhs characters of one requested line from the pair memory as a valid/ready byte stream.
// Define TRANSFORM_STREAMER_EOL_EN to append a 0x0A end-of-line character (out_last on it) to every line.
module transform_streamer #(
   parameter int CHAR_W = 8,
   parameter int ADDR_W = 8,
   parameter int LINE_W = 8,
   parameter int LEN_W  = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [LINE_W-1:0]       req_line,
   input  logic [1:0]              req_mode,
   input  logic                    abort,
   output logic [LINE_W-1:0]       ptr_line,
   input  logic [LEN_W+ADDR_W-1:0] ptr_data,
   output logic [ADDR_W-1:0]       mem_addr,
   input  logic [2*CHAR_W-1:0]     mem_dout,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [CHAR_W-1:0]       out_char,
   output logic                    out_side,
   output logic                    out_last,
   output logic                    done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOOKUP,
      S_FETCH,
      S_EMIT0,
      S_EMIT1
`ifdef TRANSFORM_STREAMER_EOL_EN
      , S_EOL
`endif
   } state_t;

   state_t              state_q, state_d;
   logic [1:0]          mode_q, mode_d;
   logic [LINE_W-1:0]   ptr_line_q, ptr_line_d;
   logic [LEN_W-1:0]    len_q, len_d;
   logic [LEN_W-1:0]    count_q, count_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [2*CHAR_W-1:0] pair_q, pair_d, pair_w;
   logic                fresh_q, fresh_d;
   logic                done_q, done_d;
   logic                last_pair, advance, side_w;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         mode_q     <= 2'b00;
         ptr_line_q <= '0;
         len_q      <= '0;
         count_q    <= '0;
         mem_addr_q <= '1;
         pair_q     <= '0;
         fresh_q    <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
         state_q    <= state_d;
         mode_q     <= mode_d;
         ptr_line_q <= ptr_line_d;
         len_q      <= len_d;
         count_q    <= count_d;
         mem_addr_q <= mem_addr_d;
         pair_q     <= pair_d;
         fresh_q    <= fresh_d;
         done_q     <= done_d;
      end
   end

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_d    = state_q;
      mode_d     = mode_q;
      ptr_line_d = ptr_line_q;
      len_d      = len_q;
      count_d    = count_q;
      mem_addr_d = mem_addr_q;
      // The first EMIT0 cycle sees the word straight from memory; later stall cycles replay the held copy.
      pair_w     = (state_q == S_EMIT0 && fresh_q) ? mem_dout : pair_q;
      pair_d     = pair_w;
      fresh_d    = 1'b0;
      done_d     = 1'b0;
      last_pair  = (count_q == len_q - LEN_W'(1));
      advance    = 1'b0;
      side_w     = 1'b0;
      out_valid  = 1'b0;
      out_char   = '0;
      out_side   = 1'b0;
      out_last   = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               mode_d     = req_mode;
               ptr_line_d = req_line;
               state_d    = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            len_d   = ptr_data[LEN_W+ADDR_W-1:ADDR_W];
            count_d = '0;
            if (ptr_data[LEN_W+ADDR_W-1:ADDR_W] == '0) begin
`ifdef TRANSFORM_STREAMER_EOL_EN
               state_d = S_EOL;
`else
               state_d = S_IDLE;
               done_d  = 1'b1;
`endif
            end else begin
               state_d    = S_FETCH;
               mem_addr_d = ptr_data[ADDR_W-1:0];
            end
         end
         S_FETCH: begin
            state_d = S_EMIT0;
            fresh_d = 1'b1;
         end
         S_EMIT0: begin
            out_valid = 1'b1;
            side_w    = mode_q[0];
            out_side  = side_w;
            out_char  = side_w ? pair_w[CHAR_W-1:0] : pair_w[2*CHAR_W-1:CHAR_W];
`ifndef TRANSFORM_STREAMER_EOL_EN
            out_last  = !mode_q[1] && last_pair;
`endif
            if (out_ready) begin
               if (mode_q[1]) state_d = S_EMIT1;
               else           advance = 1'b1;
            end
         end
         S_EMIT1: begin
            out_valid = 1'b1;
            side_w    = ~mode_q[0];
            out_side  = side_w;
            out_char  = side_w ? pair_w[CHAR_W-1:0] : pair_w[2*CHAR_W-1:CHAR_W];
`ifndef TRANSFORM_STREAMER_EOL_EN
            out_last  = last_pair;
`endif
            if (out_ready) advance = 1'b1;
         end
`ifdef TRANSFORM_STREAMER_EOL_EN
         S_EOL: begin
            out_valid = 1'b1;
            out_char  = CHAR_W'(8'h0A);
            out_last  = 1'b1;
            if (out_ready) begin
               state_d    = S_IDLE;
               done_d     = 1'b1;
               mem_addr_d = '1;
            end
         end
`endif
         default: state_d = S_IDLE;
      endcase

      if (advance) begin
         if (last_pair) begin
`ifdef TRANSFORM_STREAMER_EOL_EN
            state_d = S_EOL;
`else
            state_d    = S_IDLE;
            done_d     = 1'b1;
            mem_addr_d = '1;
`endif
         end else begin
            count_d    = count_q + LEN_W'(1);
            mem_addr_d = mem_addr_q + ADDR_W'(1);
            state_d    = S_FETCH;
         end
      end

      // Abort wins over a same-cycle handshake: that character is treated as never sent.
      if (abort && state_q != S_IDLE) begin
         state_d    = S_IDLE;
         mem_addr_d = '1;
         done_d     = 1'b0;
      end
   end

   assign req_ready = (state_q == S_IDLE);
   assign ptr_line  = ptr_line_q;
   assign mem_addr  = mem_addr_q;
   assign done      = done_q;

endmodule
